regfile_mp: RTL and testbench

//  Parametrised multi-port GPR file for the pipelined MIPS core: NUM_RD read ports, two write ports
//  (WB0 = ALU writeback, WB1 = load/mult writeback), hardwired-zero register 0, and a pending-write

---
 rtl/mips_pkg.sv | 16 +
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_rd_port.sv | 54 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-file size defaults, architectural
// register indices and the register-address type.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned ADDR_W   = $clog2(DEPTH);

    // Architectural register indices
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_V0   = 2;
    localparam int unsigned REG_A0   = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, two writeback ports, issue/scoreboard
// request and debug taps.
//   master : decode/issue/writeback side (drives addresses, writes, issue)
//   slave  : the register file (drives read data, busy flags, taps)
interface regfile_mp_if #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter int unsigned NUM_RD = 2
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic                     issue_vld;
    logic [ADDR_W-1:0]        issue_reg;
    logic [DATA_W-1:0]        a0;
    logic [DATA_W-1:0]        v0;

    modport master (
        output rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1,
               issue_vld, issue_reg,
        input  rd_data, rd_busy, a0, v0
    );

    modport slave (
        input  rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1,
               issue_vld, issue_reg,
        output rd_data, rd_busy, a0, v0
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One register-file read port: address mux with hardwired-zero r0, busy
// lookup and (with REGFILE_BYPASS_EN) same-cycle write forwarding.
//   addr        read address
//   regs, busy  storage array and pending-write flags from the top
//   we*/waddr*/wdata*  current write-port requests (used only for forwarding)
//   data_c      combinational read data
//   busy_c      combinational pending-write flag for addr
module regfile_rd_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
    input  logic [DEPTH-1:0]              busy,
    input  logic                          we0,
    input  logic [ADDR_W-1:0]             waddr0,
    input  logic [DATA_W-1:0]             wdata0,
    input  logic                          we1,
    input  logic [ADDR_W-1:0]             waddr1,
    input  logic [DATA_W-1:0]             wdata1,
    output logic [DATA_W-1:0]             data_c,
    output logic                          busy_c
);

    import mips_pkg::*;

    // Read mux; r0 always reads as zero and never busy
    always_comb begin
        data_c = '0;
        busy_c = 1'b0;
        if (addr != ADDR_W'(REG_ZERO)) begin
            data_c = regs[addr];
            busy_c = busy[addr];
`ifdef REGFILE_BYPASS_EN
            // Port 1 forwards first, matching its priority on write collisions
            if (we1 && (waddr1 == addr)) begin
                data_c = wdata1;
                busy_c = 1'b0;
            end else if (we0 && (waddr0 == addr)) begin
                data_c = wdata0;
                busy_c = 1'b0;
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Write-port inputs only matter when forwarding is built in
    logic unused_wr_c;
    assign unused_wr_c = ^{we0, waddr0, wdata0, we1, waddr1, wdata1};
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file for the pipelined MIPS core.
//   NUM_RD combinational read ports, two writeback ports (WB0 = ALU,
//   WB1 = load/mult; WB1 wins on same-address collisions), hardwired-zero r0,
//   and a pending-write scoreboard flagging load-use hazards to issue.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         regfile_mp_if.slave: rd_addr/rd_data/rd_busy, we0/waddr0/wdata0,
//               we1/waddr1/wdata1, issue_vld/issue_reg, a0 (r4) / v0 (r2) taps
// Configuration macro: REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_mp #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned DEPTH  = mips_pkg::DEPTH,
    parameter int unsigned NUM_RD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);

    import mips_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busy_nxt_c;
    logic                         wr0_ok_c;
    logic                         wr1_ok_c;
    logic                         issue_ok_c;

    // Requests aimed at r0 are dropped entirely
    assign wr0_ok_c   = bus.we0 && (bus.waddr0 != ADDR_W'(REG_ZERO));
    assign wr1_ok_c   = bus.we1 && (bus.waddr1 != ADDR_W'(REG_ZERO));
    assign issue_ok_c = bus.issue_vld && (bus.issue_reg != ADDR_W'(REG_ZERO));

    // Scoreboard update: writes clear, issue sets last so it wins a tie
    always_comb begin
        busy_nxt_c = busy;
        if (wr0_ok_c) begin
            busy_nxt_c[bus.waddr0] = 1'b0;
        end
        if (wr1_ok_c) begin
            busy_nxt_c[bus.waddr1] = 1'b0;
        end
        if (issue_ok_c) begin
            busy_nxt_c[bus.issue_reg] = 1'b1;
        end
    end

    // Storage and scoreboard; port 1 written last so it wins a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wr0_ok_c) begin
                regs[bus.waddr0] <= bus.wdata0;
            end
            if (wr1_ok_c) begin
                regs[bus.waddr1] <= bus.wdata1;
            end
            busy <= busy_nxt_c;
        end
    end

    // Read ports
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .addr   (bus.rd_addr[i*ADDR_W +: ADDR_W]),
            .regs   (regs),
            .busy   (busy),
            .we0    (bus.we0),
            .waddr0 (bus.waddr0),
            .wdata0 (bus.wdata0),
            .we1    (bus.we1),
            .waddr1 (bus.waddr1),
            .wdata1 (bus.wdata1),
            .data_c (bus.rd_data[i*DATA_W +: DATA_W]),
            .busy_c (bus.rd_busy[i])
        );
    end

    // Debug taps straight from storage (no forwarding); absent registers read 0
    if (DEPTH > REG_V0) begin : g_v0
        assign bus.v0 = regs[ADDR_W'(REG_V0)];
    end else begin : g_no_v0
        assign bus.v0 = '0;
    end

    if (DEPTH > REG_A0) begin : g_a0
        assign bus.a0 = regs[ADDR_W'(REG_A0)];
    end else begin : g_no_a0
        assign bus.a0 = '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a default 32x32/2-read instance and a
// 16-bit, 8-entry, 3-read instance, each checked against an array model on
// every falling edge, plus hand-computed expectations at key points.
module tb_regfile_mp;

    localparam int unsigned BW = 32;
    localparam int unsigned BD = 32;
    localparam int unsigned BA = 5;
    localparam int unsigned BN = 2;
    localparam int unsigned SW = 16;
    localparam int unsigned SD = 8;
    localparam int unsigned SA = 3;
    localparam int unsigned SN = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(BW), .ADDR_W(BA), .NUM_RD(BN)) bb ();
    regfile_mp_if #(.DATA_W(SW), .ADDR_W(SA), .NUM_RD(SN)) bs ();

    regfile_mp #(.DATA_W(BW), .DEPTH(BD), .NUM_RD(BN)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bb.slave)
    );

    regfile_mp #(.DATA_W(SW), .DEPTH(SD), .NUM_RD(SN)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.slave)
    );

    // ---------------- model: k=0 big instance, k=1 small instance ----------
    logic [31:0] mreg  [2][32];
    logic        mbusy [2][32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 32; r++) begin
                    mreg[k][r]  <= '0;
                    mbusy[k][r] <= 1'b0;
                end
            end
        end else begin
            if (bb.we0 && bb.waddr0 != 0) begin
                mreg[0][bb.waddr0]  <= bb.wdata0;
                mbusy[0][bb.waddr0] <= 1'b0;
            end
            if (bb.we1 && bb.waddr1 != 0) begin
                mreg[0][bb.waddr1]  <= bb.wdata1;
                mbusy[0][bb.waddr1] <= 1'b0;
            end
            if (bb.issue_vld && bb.issue_reg != 0) mbusy[0][bb.issue_reg] <= 1'b1;
            if (bs.we0 && bs.waddr0 != 0) begin
                mreg[1][bs.waddr0]  <= 32'(bs.wdata0);
                mbusy[1][bs.waddr0] <= 1'b0;
            end
            if (bs.we1 && bs.waddr1 != 0) begin
                mreg[1][bs.waddr1]  <= 32'(bs.wdata1);
                mbusy[1][bs.waddr1] <= 1'b0;
            end
            if (bs.issue_vld && bs.issue_reg != 0) mbusy[1][bs.issue_reg] <= 1'b1;
        end
    end

    // Expected {busy, data} for a read of address a given the current writes
    function automatic logic [32:0] exp_rd(int k, int a, logic we0, int wa0,
                                           logic [31:0] wd0, logic we1, int wa1,
                                           logic [31:0] wd1);
        logic [31:0] d;
        logic        b;
        if (a == 0) return 33'd0;
        d = mreg[k][a];
        b = mbusy[k][a];
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == a) begin
            d = wd1;
            b = 1'b0;
        end else if (we0 && wa0 == a) begin
            d = wd0;
            b = 1'b0;
        end
`else
        if (we0 && we1 && wa0 == wa1 && wd0 == wd1) d = d; // no forwarding
`endif
        return {b, d};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        for (int i = 0; i < int'(BN); i++) begin
            e = exp_rd(0, int'(bb.rd_addr[i*BA +: BA]), bb.we0, int'(bb.waddr0),
                       bb.wdata0, bb.we1, int'(bb.waddr1), bb.wdata1);
            check($sformatf("big rd_data[%0d]", i), bb.rd_data[i*BW +: BW], e[31:0]);
            check($sformatf("big rd_busy[%0d]", i), 32'(bb.rd_busy[i]), 32'(e[32]));
        end
        check("big a0", bb.a0, mreg[0][4]);
        check("big v0", bb.v0, mreg[0][2]);
        for (int i = 0; i < int'(SN); i++) begin
            e = exp_rd(1, int'(bs.rd_addr[i*SA +: SA]), bs.we0, int'(bs.waddr0),
                       32'(bs.wdata0), bs.we1, int'(bs.waddr1), 32'(bs.wdata1));
            check($sformatf("small rd_data[%0d]", i), 32'(bs.rd_data[i*SW +: SW]), e[31:0]);
            check($sformatf("small rd_busy[%0d]", i), 32'(bs.rd_busy[i]), 32'(e[32]));
        end
        check("small a0", 32'(bs.a0), mreg[1][4]);
        check("small v0", 32'(bs.v0), mreg[1][2]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_b();
        bb.we0 = 1'b0; bb.waddr0 = '0; bb.wdata0 = '0;
        bb.we1 = 1'b0; bb.waddr1 = '0; bb.wdata1 = '0;
        bb.issue_vld = 1'b0; bb.issue_reg = '0;
    endtask

    task automatic clr_s();
        bs.we0 = 1'b0; bs.waddr0 = '0; bs.wdata0 = '0;
        bs.we1 = 1'b0; bs.waddr1 = '0; bs.wdata1 = '0;
        bs.issue_vld = 1'b0; bs.issue_reg = '0;
    endtask

    task automatic wr_b(int p, int a, logic [31:0] d);
        if (p == 0) begin
            bb.we0 = 1'b1; bb.waddr0 = BA'(a); bb.wdata0 = d;
        end else begin
            bb.we1 = 1'b1; bb.waddr1 = BA'(a); bb.wdata1 = d;
        end
    endtask

    task automatic issue_b(int a);
        bb.issue_vld = 1'b1;
        bb.issue_reg = BA'(a);
    endtask

    task automatic rd_b(int a0, int a1);
        bb.rd_addr = {BA'(a1), BA'(a0)};
    endtask

    // ---------------- directed tests ----------------
    initial begin
        clr_b();
        clr_s();
        bb.rd_addr = '0;
        bs.rd_addr = '0;
        #1 rst_n = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        // Reset state
        check("reset rd_data0", bb.rd_data[BW-1:0], 32'h0);
        check("reset rd_busy", 32'(bb.rd_busy), 32'h0);
        check("reset a0", bb.a0, 32'h0);

        // Collision on r7: port 1 wins
        rd_b(7, 7);
        wr_b(0, 7, 32'h11111111);
        wr_b(1, 7, 32'h22222222);
        tick();
        clr_b();
        #3 check("collision r7", bb.rd_data[BW-1:0], 32'h22222222);
        tick();

        // Zero register: writes and issue to r0 are ignored
        rd_b(0, 0);
        wr_b(0, 0, 32'hFFFFFFFF);
        issue_b(0);
        tick();
        clr_b();
        #3;
        check("r0 data", bb.rd_data[BW-1:0], 32'h0);
        check("r0 busy", 32'(bb.rd_busy), 32'h0);
        tick();

        // Scoreboard on r9, port 1 keeps watching r7
        rd_b(9, 7);
        issue_b(9);
        tick();
        clr_b();
        for (int c = 0; c < 3; c++) begin
            #3 check("r9 busy idle", 32'(bb.rd_busy[0]), 32'h1);
            tick();
        end
        wr_b(1, 9, 32'h00000042);
        tick();
        clr_b();
        #3;
        check("r9 busy cleared", 32'(bb.rd_busy[0]), 32'h0);
        check("r9 data", bb.rd_data[BW-1:0], 32'h00000042);
        check("r7 on port1", bb.rd_data[2*BW-1:BW], 32'h22222222);
        tick();
        issue_b(9);
        wr_b(0, 9, 32'h00000055);
        tick();
        clr_b();
        #3;
        check("r9 set wins", 32'(bb.rd_busy[0]), 32'h1);
        check("r9 data 55", bb.rd_data[BW-1:0], 32'h00000055);
        tick();
        wr_b(1, 9, 32'h00000077);
        tick();
        clr_b();

        // Bypass on r3 while r3 is busy
        wr_b(0, 3, 32'h01010101);
        tick();
        clr_b();
        issue_b(3);
        tick();
        clr_b();
        rd_b(3, 9);
        wr_b(0, 3, 32'hCAFEF00D);
        #3;
`ifdef REGFILE_BYPASS_EN
        check("bypass data", bb.rd_data[BW-1:0], 32'hCAFEF00D);
        check("bypass busy", 32'(bb.rd_busy[0]), 32'h0);
`else
        check("no-bypass data", bb.rd_data[BW-1:0], 32'h01010101);
        check("no-bypass busy", 32'(bb.rd_busy[0]), 32'h1);
`endif
        tick();
        clr_b();
        #3;
        check("r3 after write", bb.rd_data[BW-1:0], 32'hCAFEF00D);
        check("r3 busy after", 32'(bb.rd_busy[0]), 32'h0);
        tick();

        // Debug taps, then reset asserted mid-write
        rd_b(5, 2);
        wr_b(0, 5, 32'hDEADBEEF);
        wr_b(1, 4, 32'hA0A0A0A0);
        tick();
        clr_b();
        wr_b(0, 2, 32'h0000BEEF);
        issue_b(5);
        tick();
        clr_b();
        #3;
        check("r5 before reset", bb.rd_data[BW-1:0], 32'hDEADBEEF);
        check("r5 busy", 32'(bb.rd_busy[0]), 32'h1);
        check("a0 tap", bb.a0, 32'hA0A0A0A0);
        check("v0 tap", bb.v0, 32'h0000BEEF);
        tick();
        wr_b(0, 5, 32'h12345678);
        #1 rst_n = 1'b0;
        clr_b();
        #1;
        check("async rst data", bb.rd_data[BW-1:0], 32'h0);
        check("async rst busy", 32'(bb.rd_busy), 32'h0);
        check("async rst a0", bb.a0, 32'h0);
        check("async rst v0", bb.v0, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        #3 check("r5 after reset", bb.rd_data[BW-1:0], 32'h0);
        tick();

        // Small instance: 16-bit, 8 entries, 3 read ports
        bs.rd_addr = {3'd7, 3'd4, 3'd2};
        bs.we0 = 1'b1; bs.waddr0 = 3'd2; bs.wdata0 = 16'h1234;
        bs.we1 = 1'b1; bs.waddr1 = 3'd4; bs.wdata1 = 16'hABCD;
        tick();
        clr_s();
        bs.we0 = 1'b1; bs.waddr0 = 3'd7; bs.wdata0 = 16'h7777;
        tick();
        clr_s();
        #3;
        check("small v0", 32'(bs.v0), 32'h1234);
        check("small a0", 32'(bs.a0), 32'hABCD);
        check("small port0", 32'(bs.rd_data[15:0]), 32'h1234);
        check("small port1", 32'(bs.rd_data[31:16]), 32'hABCD);
        check("small port2", 32'(bs.rd_data[47:32]), 32'h7777);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
